// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port byte-memory arbiter: access-type codes,
// FSM state encoding, default address width and access-type decode helpers.
package mem_arbiter_pkg;

    localparam int MEM_AW_DEF = 10;

    localparam logic [2:0] DM_B  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_W  = 3'b010;
    localparam logic [2:0] DM_BU = 3'b100;
    localparam logic [2:0] DM_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Low two bits carry the size; 110 therefore decodes as a word load.
    function automatic logic [2:0] dm_nbytes(input logic [2:0] dm);
        case (dm[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Stores have no unsigned variants, so any 1xx store is rejected.
    function automatic logic dm_illegal(input logic we, input logic [2:0] dm);
        if (dm[1:0] == 2'b11) return 1'b1;
        if (we && dm[2])      return 1'b1;
        return 1'b0;
    endfunction

endpackage

// File: rtl/mem_arbiter_ld_extend.sv
// Combinational sign/zero extension of assembled little-endian load bytes.
module ld_extend
    import mem_arbiter_pkg::*;
(
    input  logic [2:0]  dmtype_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = data_i;
        case (dmtype_i)
            DM_B:    data_o = {{24{data_i[7]}}, data_i[7:0]};
            DM_H:    data_o = {{16{data_i[15]}}, data_i[15:0]};
            DM_BU:   data_o = {24'd0, data_i[7:0]};
            DM_HU:   data_o = {16'd0, data_i[15:0]};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that serialises 32-bit loads/stores from two ports onto
// a byte-wide memory with one-cycle read latency.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_AW = MEM_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p1_req,
    input  logic              p0_we,
    input  logic              p1_we,
    input  logic [2:0]        p0_dmtype,
    input  logic [2:0]        p1_dmtype,
    input  logic [31:0]       p0_addr,
    input  logic [31:0]       p1_addr,
    input  logic [31:0]       p0_wdata,
    input  logic [31:0]       p1_wdata,
    output logic              p0_ack,
    output logic              p1_ack,
    output logic [31:0]       p0_rdata,
    output logic [31:0]       p1_rdata,
    output logic              p0_err,
    output logic              p1_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    logic [1:0]        req_a;
    logic [1:0]        we_a;
    logic [2:0]        dm_a    [2];
    logic [MEM_AW-1:0] addr_a  [2];
    logic [31:0]       wdata_a [2];
    logic [1:0]        ack_a;
    logic [1:0]        err_a;
    logic              unused_addr_hi;

    assign req_a      = {p1_req, p0_req};
    assign we_a       = {p1_we, p0_we};
    assign dm_a[0]    = p0_dmtype;
    assign dm_a[1]    = p1_dmtype;
    assign addr_a[0]  = p0_addr[MEM_AW-1:0];
    assign addr_a[1]  = p1_addr[MEM_AW-1:0];
    assign wdata_a[0] = p0_wdata;
    assign wdata_a[1] = p1_wdata;
    assign unused_addr_hi = ^{p0_addr[31:MEM_AW], p1_addr[31:MEM_AW]};

    state_e            state_q, state_d;
    logic              gnt_q;
    logic              last_q;
    logic              we_q;
    logic [2:0]        dm_q;
    logic [MEM_AW-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        cnt_q;
    logic              err_q;
    logic [31:0]       rbuf_q;

    logic              gnt_sel;
    logic              sel_illegal;
    logic [2:0]        nbytes;
    logic [1:0]        lane;
    logic [31:0]       merged;
    logic [31:0]       ext_data;
    logic              rd_wr_en;
    logic              rd_wr_port;
    logic [31:0]       rd_wr_val;

    // With both requesting, the port that did not win last time goes next.
    assign gnt_sel     = (req_a == 2'b11) ? ~last_q : req_a[1];
    assign sel_illegal = dm_illegal(we_a[gnt_sel], dm_a[gnt_sel]);
    assign nbytes      = dm_nbytes(dm_q);
    assign lane        = 2'(cnt_q - 3'd1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (|req_a) state_d = sel_illegal ? ST_DONE : ST_ACCESS;
            ST_ACCESS: if (cnt_q == (nbytes - 3'd1)) state_d = we_q ? ST_DONE : ST_DRAIN;
            ST_DRAIN:  state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            dm_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            cnt_q   <= 3'd0;
            err_q   <= 1'b0;
            rbuf_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (|req_a) begin
                        gnt_q   <= gnt_sel;
                        last_q  <= gnt_sel;
                        we_q    <= we_a[gnt_sel];
                        dm_q    <= dm_a[gnt_sel];
                        addr_q  <= addr_a[gnt_sel];
                        wdata_q <= wdata_a[gnt_sel];
                        err_q   <= sel_illegal;
                        cnt_q   <= 3'd0;
                        rbuf_q  <= 32'd0;
                    end
                end
                ST_ACCESS: begin
                    cnt_q <= cnt_q + 3'd1;
                    // mem_rdata now holds the byte issued on the previous cycle.
                    if (!we_q && cnt_q != 3'd0) rbuf_q[{lane, 3'b000} +: 8] <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

    // The final load byte arrives during DRAIN; fold it in before extension.
    always_comb begin
        merged = rbuf_q;
        merged[{lane, 3'b000} +: 8] = mem_rdata;
    end

    ld_extend u_ld_extend (
        .dmtype_i (dm_q),
        .data_i   (merged),
        .data_o   (ext_data)
    );

    assign rd_wr_en   = (state_q == ST_DRAIN) ||
                        ((state_q == ST_IDLE) && (|req_a) && sel_illegal);
    assign rd_wr_port = (state_q == ST_IDLE) ? gnt_sel : gnt_q;
    assign rd_wr_val  = (state_q == ST_IDLE) ? 32'd0 : ext_data;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [31:0] rdata_q;

            always_ff @(posedge clk) begin
                if (rst)
                    rdata_q <= 32'd0;
                else if (rd_wr_en && rd_wr_port == 1'(gi))
                    rdata_q <= rd_wr_val;
            end

            assign ack_a[gi] = (state_q == ST_DONE) && (gnt_q == 1'(gi));
            assign err_a[gi] = ack_a[gi] && err_q;
        end
    endgenerate

    assign p0_rdata  = g_port[0].rdata_q;
    assign p1_rdata  = g_port[1].rdata_q;
    assign p0_ack    = ack_a[0];
    assign p1_ack    = ack_a[1];
    assign p0_err    = err_a[0];
    assign p1_err    = err_a[1];

    assign mem_en    = (state_q == ST_ACCESS);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = addr_q + MEM_AW'(cnt_q);
    assign mem_wdata = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural byte memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p1_req, p0_we, p1_we;
    logic [2:0]  p0_dmtype, p1_dmtype;
    logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
    logic        p0_ack, p1_ack, p0_err, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;

    logic [7:0]  mem [1024];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .p0_req    (p0_req),
        .p1_req    (p1_req),
        .p0_we     (p0_we),
        .p1_we     (p1_we),
        .p0_dmtype (p0_dmtype),
        .p1_dmtype (p1_dmtype),
        .p0_addr   (p0_addr),
        .p1_addr   (p1_addr),
        .p0_wdata  (p0_wdata),
        .p1_wdata  (p1_wdata),
        .p0_ack    (p0_ack),
        .p1_ack    (p1_ack),
        .p0_rdata  (p0_rdata),
        .p1_rdata  (p1_rdata),
        .p0_err    (p0_err),
        .p1_err    (p1_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // Entered and left at 1 time unit after a rising edge, with the DUT idle.
    task automatic xfer(input int port, input logic we, input logic [2:0] dm,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int en_cnt);
        logic got;
        logic ack;
        got = 1'b0; lat = 0; en_cnt = 0; rdata = 32'd0; err = 1'b0;
        if (port == 0) begin
            p0_we = we; p0_dmtype = dm; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
        end else begin
            p1_we = we; p1_dmtype = dm; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
        end
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (mem_en) en_cnt++;
            ack = (port == 0) ? p0_ack : p1_ack;
            if (ack) begin
                got   = 1'b1;
                rdata = (port == 0) ? p0_rdata : p1_rdata;
                err   = (port == 0) ? p0_err : p1_err;
            end
        end
        check("ack_seen", 32'(got), 32'd1);
        @(posedge clk); #1;
        if (port == 0) p0_req = 1'b0; else p1_req = 1'b0;
        $display("xfer p%0d we=%0d dm=%03b addr=%08h wdata=%08h -> rdata=%08h err=%0d lat=%0d",
                 port, we, dm, addr, wdata, rdata, err, lat);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, en;
        int          p0_at, p1_at, idle_cnt, ack_cnt;

        rst = 1'b1;
        p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0;
        p0_dmtype = 0; p1_dmtype = 0; p0_addr = 0; p1_addr = 0; p0_wdata = 0; p1_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_ack",    32'({p1_ack, p0_ack}), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_rdata0", p0_rdata, 32'd0);
        check("rst_rdata1", p1_rdata, 32'd0);

        // Contention straight out of reset: both sb, p0 must win first.
        rst = 1'b0;
        p0_we = 1; p0_dmtype = 3'b000; p0_addr = 32'h20; p0_wdata = 32'h000000A1;
        p1_we = 1; p1_dmtype = 3'b000; p1_addr = 32'h21; p1_wdata = 32'h000000B2;
        p0_req = 1; p1_req = 1;
        p0_at = -1; p1_at = -1; idle_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (p0_at >= 0 && c == p0_at + 1) p0_req = 1'b0;
            if (p1_at >= 0 && c == p1_at + 1) begin
                p1_req = 1'b0;
                break;
            end
            if (!busy) idle_cnt++;
            if (p0_ack && p0_at < 0) p0_at = c;
            if (p1_ack && p1_at < 0) p1_at = c;
        end
        $display("xfer contention p0_ack@%0d p1_ack@%0d idle=%0d", p0_at, p1_at, idle_cnt);
        check("cont_p0_at",  32'(p0_at),    32'd1);
        check("cont_p1_at",  32'(p1_at),    32'd4);
        check("cont_idle",   32'(idle_cnt), 32'd1);
        check("cont_mem20",  32'(mem[10'h20]), 32'hA1);
        check("cont_mem21",  32'(mem[10'h21]), 32'hB2);

        xfer(0, 1'b1, 3'b010, 32'h10, 32'h8899AABB, rd, er, lat, en);
        check("sw_lat",   32'(lat), 32'd5);
        check("sw_err",   32'(er),  32'd0);
        check("sw_mem",   {mem[10'h13], mem[10'h12], mem[10'h11], mem[10'h10]}, 32'h8899AABB);
        check("sw_rdata", p0_rdata, 32'd0);

        xfer(0, 1'b0, 3'b010, 32'h10, 32'd0, rd, er, lat, en);
        check("lw_lat",   32'(lat), 32'd6);
        check("lw_rdata", rd, 32'h8899AABB);

        xfer(1, 1'b0, 3'b000, 32'h10, 32'd0, rd, er, lat, en);
        check("lb_lat",   32'(lat), 32'd3);
        check("lb_rdata", rd, 32'hFFFFFFBB);
        xfer(0, 1'b0, 3'b100, 32'h10, 32'd0, rd, er, lat, en);
        check("lbu_rdata", rd, 32'h000000BB);
        xfer(1, 1'b0, 3'b001, 32'h10, 32'd0, rd, er, lat, en);
        check("lh_lat",   32'(lat), 32'd4);
        check("lh_rdata", rd, 32'hFFFFAABB);
        xfer(0, 1'b0, 3'b101, 32'h10, 32'd0, rd, er, lat, en);
        check("lhu_rdata", rd, 32'h0000AABB);

        xfer(0, 1'b1, 3'b010, 32'h3FE, 32'h11223344, rd, er, lat, en);
        check("wrap_mem3fe", 32'(mem[10'h3FE]), 32'h44);
        check("wrap_mem3ff", 32'(mem[10'h3FF]), 32'h33);
        check("wrap_mem000", 32'(mem[10'h000]), 32'h22);
        check("wrap_mem001", 32'(mem[10'h001]), 32'h11);
        check("st_keeps_rdata", p0_rdata, 32'h0000AABB);
        xfer(1, 1'b0, 3'b110, 32'h3FE, 32'd0, rd, er, lat, en);
        check("wrap_lw_rdata", rd, 32'h11223344);

        xfer(0, 1'b0, 3'b011, 32'h10, 32'd0, rd, er, lat, en);
        check("ill_lat",   32'(lat), 32'd1);
        check("ill_err",   32'(er),  32'd1);
        check("ill_rdata", rd, 32'd0);
        check("ill_mem_en", 32'(en), 32'd0);
        xfer(1, 1'b1, 3'b100, 32'h10, 32'h12345678, rd, er, lat, en);
        check("ill_st_err",   32'(er), 32'd1);
        check("ill_st_rdata", rd, 32'd0);
        check("ill_st_mem_en", 32'(en), 32'd0);
        check("ill_st_mem",   {mem[10'h13], mem[10'h12], mem[10'h11], mem[10'h10]}, 32'h8899AABB);

        // Reset during the second ACCESS cycle of a word store.
        xfer(0, 1'b1, 3'b010, 32'h40, 32'h5A5A5A5A, rd, er, lat, en);
        p0_we = 1; p0_dmtype = 3'b010; p0_addr = 32'h40; p0_wdata = 32'hDDCCBBAA; p0_req = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; p0_req = 1'b0;
        @(posedge clk); #1;
        check("abort_busy",  32'(busy),   32'd0);
        check("abort_ack",   32'(p0_ack), 32'd0);
        check("abort_rdata", p0_rdata,    32'd0);
        rst = 1'b0;
        ack_cnt = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (p0_ack || p1_ack || mem_en) ack_cnt++;
        end
        $display("xfer abort: reset mid-store, quiet cycles checked");
        check("abort_quiet",  32'(ack_cnt), 32'd0);
        check("abort_byte0",  32'(mem[10'h40]), 32'hAA);
        check("abort_byte2",  32'(mem[10'h42]), 32'h5A);
        check("abort_byte3",  32'(mem[10'h43]), 32'h5A);
        xfer(1, 1'b0, 3'b010, 32'h40, 32'd0, rd, er, lat, en);
        check("post_abort_lw", rd, 32'h5A5ABBAA);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
